// File: rtl/conv3x3_accumulator.sv
// 3x3 convolution over a 3-channel window, one channel per cycle, for four filters in turn.
// Weights come from an external mux addressed by chanel/filter_used; each filter's sum is offered on a valid/ready port.
module conv3x3_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 2*WIDTH+6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                win_valid,
    output logic                                win_ready,
    input  logic [2:0][2:0][2:0][WIDTH-1:0]     Window,
    output logic [1:0]                          chanel,
    output logic [1:0]                          filter_used,
    input  logic [2:0][2:0][WIDTH-1:0]          Kernel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ACC_WIDTH-1:0]         out_data,
    output logic [1:0]                          out_filter,
    output logic                                frame_done
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                              state_q, state_d;
    logic [2:0][2:0][2:0][WIDTH-1:0]     win_q, win_d;
    logic signed [ACC_WIDTH-1:0]         acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]         term_c;
    logic [1:0]                          chanel_d, filter_d, out_filter_d;
    logic                                out_valid_d, frame_done_d, win_ready_d;
    logic signed [ACC_WIDTH-1:0]         out_data_d;

    // One channel's 3x3 dot product: unsigned pixels (zero-extended) times signed weights
    always_comb begin
        term_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                term_c = term_c
                       + ACC_WIDTH'($signed({1'b0, win_q[r][k][chanel]}))
                       * ACC_WIDTH'($signed(Kernel[r][k]));
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        acc_d        = acc_q;
        chanel_d     = chanel;
        filter_d     = filter_used;
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        out_filter_d = out_filter;
        frame_done_d = 1'b0;
        win_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid && win_ready) begin
                    win_d    = Window;
                    acc_d    = '0;
                    chanel_d = 2'd0;
                    filter_d = 2'd0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (chanel == 2'd2) begin
                    out_data_d   = acc_q + term_c;
                    out_filter_d = filter_used;
                    out_valid_d  = 1'b1;
                    state_d      = OUTPUT;
                end else begin
                    acc_d    = acc_q + term_c;
                    chanel_d = chanel + 2'd1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    chanel_d    = 2'd0;
                    if (filter_used == 2'd3) begin
                        filter_d     = 2'd0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        filter_d = filter_used + 2'd1;
                        acc_d    = '0;
                        state_d  = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The frame_done cycle is spent in IDLE but still refuses a window
        win_ready_d = (state_d == IDLE) && !frame_done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            acc_q       <= '0;
            chanel      <= 2'd0;
            filter_used <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_filter  <= 2'd0;
            frame_done  <= 1'b0;
            win_ready   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            chanel      <= chanel_d;
            filter_used <= filter_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_filter  <= out_filter_d;
            frame_done  <= frame_done_d;
            win_ready   <= win_ready_d;
        end
    end

endmodule
